rf_wb_arb: RTL and testbench

Write-back arbiter that owns the single write port of the 32×32 register file (2 read ports, 1 write port, r0 hardwired to zero). It merges two result sources: the in-order pipeline WB stage, which always wins and never stalls, and a long-latency unit (mul/div, uncached load) whose results are buffered in a small in-order FIFO and drained into idle write-port cycles. It also reports to ID which source registers have a pending buffered write, so ID can stall or forward.

---
 rtl/rf_wb_arb_pkg.sv | 26 ++
 rtl/rf_wb_arb_if.sv | 45 ++++
 rtl/rf_wb_fifo.sv | 84 ++++++++
 rtl/rf_wb_arb.sv | 134 +++++++++++++
 tb/tb_rf_wb_arb.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arb_pkg
// Purpose  : Shared widths and the buffered write-back entry type used by the
//            write-back arbiter, its interface and its FIFO.
// Contents : RF_ADDR_W, RF_DATA_W, rf_addr_t, rf_data_t, wb_entry_t
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // kill marks an entry overwritten by a younger pipeline WB write; the entry
  // still occupies its slot and pops in order, but never reaches the RF.
  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
    logic     kill;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_wb_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arb_if
// Purpose  : Bundles the WB, long-latency, register-file and ID hazard
//            signals of the write-back arbiter.
// Modports : slave  - the arbiter (consumes wb_*/ll_*/raddr*, drives rf_*,
//                     ll_ready, busy*, fwd*)
//            master - the surrounding pipeline / testbench
// Revision : 1.0 - initial release
// ============================================================================
interface rf_wb_arb_if;
  import rf_wb_arb_pkg::*;

  logic     wb_valid;
  rf_addr_t wb_addr;
  rf_data_t wb_data;
  logic     ll_valid;
  logic     ll_ready;
  rf_addr_t ll_addr;
  rf_data_t ll_data;
  logic     rf_we;
  rf_addr_t rf_waddr;
  rf_data_t rf_wdata;
  rf_addr_t raddr1;
  rf_addr_t raddr2;
  logic     busy1;
  logic     busy2;
  logic     fwd1_valid;
  logic     fwd2_valid;
  rf_data_t fwd1_data;
  rf_data_t fwd2_data;

  modport slave (
    input  wb_valid, wb_addr, wb_data, ll_valid, ll_addr, ll_data, raddr1, raddr2,
    output ll_ready, rf_we, rf_waddr, rf_wdata, busy1, busy2,
           fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );

  modport master (
    output wb_valid, wb_addr, wb_data, ll_valid, ll_addr, ll_data, raddr1, raddr2,
    input  ll_ready, rf_we, rf_waddr, rf_wdata, busy1, busy2,
           fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
  );
endinterface
`default_nettype wire

// File: rtl/rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_fifo
// Purpose  : In-order buffer of long-latency write-back results with a
//            kill-by-address broadcast and an age-ordered view of all slots.
// Ports    : clk, reset (async, active-high)
//            i_push/i_push_entry  enqueue (ignored when full)
//            i_pop                dequeue head (ignored when empty)
//            i_kill_en/i_kill_addr set kill on every valid matching entry
//            o_full/o_empty       from the registered count
//            o_age_entry/o_age_valid  slot k = k-th oldest entry (0 = head)
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_fifo
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  input  logic             i_kill_en,
  input  rf_addr_t         i_kill_addr,
  output logic             o_full,
  output logic             o_empty,
  output wb_entry_t        o_age_entry [DEPTH],
  output logic [DEPTH-1:0] o_age_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] w_slot_valid;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_age_entry[i]  = r_mem[r_rd_ptr + PTR_W'(i)];
      o_age_valid[i]  = (CNT_W'(i) < r_count);
      w_slot_valid[i] = ({1'b0, PTR_W'(i) - r_rd_ptr} < r_count);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // The push slot is never valid here (push only when not full), so the
      // broadcast and the enqueue never target the same slot.
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && w_slot_valid[i] && (r_mem[i].addr == i_kill_addr))
          r_mem[i].kill <= 1'b1;
      end
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arb
// Purpose  : Owns the single register-file write port. Pipeline WB always
//            wins; long-latency results are buffered in order and drained
//            into idle write cycles. Reports pending buffered writes to ID.
// Ports    : clk, reset (async, active-high), bus (rf_wb_arb_if.slave)
// Config   : RF_WB_FWD_EN - when defined, ID reads hitting a buffered entry
//            are forwarded from the youngest match instead of stalling.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arb
  import rf_wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  rf_wb_arb_if.slave  bus
);

  logic             w_eff_wb;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  wb_entry_t        w_push_entry;
  wb_entry_t        w_age_entry [DEPTH];
  logic [DEPTH-1:0] w_age_valid;
  logic             w_hit1;
  logic             w_hit2;
  rf_data_t         w_fwd_data1;
  rf_data_t         w_fwd_data2;

  assign w_eff_wb = bus.wb_valid && (bus.wb_addr != '0);

  // Writes to r0 complete the handshake but are never stored.
  assign w_push = bus.ll_valid && !w_full && (bus.ll_addr != '0);
  // A WB write in the same cycle to the same register is younger.
  assign w_push_entry = '{addr: bus.ll_addr, data: bus.ll_data,
                          kill: w_eff_wb && (bus.wb_addr == bus.ll_addr)};
  // Head pops whenever WB leaves the port idle, killed or not.
  assign w_pop = !w_eff_wb && !w_empty;

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill_en    (w_eff_wb),
    .i_kill_addr  (bus.wb_addr),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_age_entry  (w_age_entry),
    .o_age_valid  (w_age_valid)
  );

  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_valid[k] && !w_age_entry[k].kill) begin
        if (w_age_entry[k].addr == bus.raddr1) w_hit1 = 1'b1;
        if (w_age_entry[k].addr == bus.raddr2) w_hit2 = 1'b1;
      end
    end
    if (bus.raddr1 == '0) w_hit1 = 1'b0;
    if (bus.raddr2 == '0) w_hit2 = 1'b0;
  end

`ifdef RF_WB_FWD_EN
  // Scan oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    w_fwd_data1 = '0;
    w_fwd_data2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_valid[k] && !w_age_entry[k].kill) begin
        if (w_age_entry[k].addr == bus.raddr1) w_fwd_data1 = w_age_entry[k].data;
        if (w_age_entry[k].addr == bus.raddr2) w_fwd_data2 = w_age_entry[k].data;
      end
    end
  end
`else
  logic w_unused_data;
  always_comb begin
    w_unused_data = 1'b0;
    for (int k = 1; k < DEPTH; k++) w_unused_data = w_unused_data ^ (^w_age_entry[k].data);
  end
  assign w_fwd_data1 = '0;
  assign w_fwd_data2 = '0;
`endif

  // All outputs are forced quiet while reset is asserted.
  always_comb begin
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = '0;
    bus.rf_wdata   = '0;
    bus.ll_ready   = 1'b0;
    bus.busy1      = 1'b0;
    bus.busy2      = 1'b0;
    bus.fwd1_valid = 1'b0;
    bus.fwd2_valid = 1'b0;
    bus.fwd1_data  = '0;
    bus.fwd2_data  = '0;
    if (!reset) begin
      bus.ll_ready = !w_full;
      if (w_eff_wb) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_addr;
        bus.rf_wdata = bus.wb_data;
      end else if (!w_empty && !w_age_entry[0].kill) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = w_age_entry[0].addr;
        bus.rf_wdata = w_age_entry[0].data;
      end
`ifdef RF_WB_FWD_EN
      bus.fwd1_valid = w_hit1;
      bus.fwd2_valid = w_hit2;
      bus.fwd1_data  = w_hit1 ? w_fwd_data1 : '0;
      bus.fwd2_data  = w_hit2 ? w_fwd_data2 : '0;
      bus.busy1      = 1'b0;
      bus.busy2      = 1'b0;
`else
      bus.busy1      = w_hit1;
      bus.busy2      = w_hit2;
      bus.fwd1_data  = w_fwd_data1;
      bus.fwd2_data  = w_fwd_data2;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arb
// Purpose  : Directed self-checking bench for rf_wb_arb. Inputs change just
//            after the falling edge; outputs are checked 1 time unit later.
// Config   : RF_WB_FWD_EN selects the forwarding expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arb;
  import rf_wb_arb_pkg::*;

`ifdef RF_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_wb_arb_if bus ();

  rf_wb_arb #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.wb_valid = wv; bus.wb_addr = wa; bus.wb_data = wd;
    bus.ll_valid = lv; bus.ll_addr = la; bus.ll_data = ld;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
    bus.raddr1 = 5'd6; bus.raddr2 = 5'd6;
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr got %0d exp 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata got %0h exp 0", bus.rf_wdata); end
    checks++; if (bus.ll_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", bus.ll_ready); end
    checks++; if ({bus.busy1, bus.busy2, bus.fwd1_valid, bus.fwd2_valid} !== 4'b0) begin
      errors++; $display("FAIL rst_hazard got %b exp 0000", {bus.busy1, bus.busy2, bus.fwd1_valid, bus.fwd2_valid}); end
    checks++; if ({bus.fwd1_data, bus.fwd2_data} !== 64'd0) begin
      errors++; $display("FAIL rst_fwd_data got %0h exp 0", {bus.fwd1_data, bus.fwd2_data}); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    reset = 1'b0;
    #1;
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b exp 1", bus.ll_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_we got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_wb_write();
    next_cycle();
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL wb_we got %0b exp 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL wb_waddr got %0d exp 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'h11) begin errors++; $display("FAIL wb_wdata got %0h exp 11", bus.rf_wdata); end
    next_cycle();
    drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL wb_r0_we got %0b exp 0", bus.rf_we); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL wb_fifo_untouched got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_ll_drain();
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL ll_same_cycle_we got %0b exp 0", bus.rf_we); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'hAA}) begin
      errors++; $display("FAIL ll_drain got we=%0b a=%0d d=%0h exp we=1 a=7 d=aa", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    next_cycle();
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL ll_empty_after got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1'b1, 5'd1, 32'h100, 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      #1;
      checks++; if (bus.ll_ready !== (i < 4)) begin
        errors++; $display("FAIL fill_ready[%0d] got %0b exp %0b", i, bus.ll_ready, (i < 4)); end
      checks++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd1}) begin
        errors++; $display("FAIL fill_wb[%0d] got we=%0b a=%0d exp we=1 a=1", i, bus.rf_we, bus.rf_waddr); end
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
      checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'(10 + i), 32'hA0 + 32'(i)}) begin
        errors++; $display("FAIL drain[%0d] got we=%0b a=%0d d=%0h exp we=1 a=%0d d=%0h",
                           i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, 10 + i, 32'hA0 + 32'(i)); end
      checks++; if (bus.ll_ready !== (i != 0)) begin
        errors++; $display("FAIL drain_ready[%0d] got %0b exp %0b", i, bus.ll_ready, (i != 0)); end
    end
    next_cycle();
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL drain_done_we got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_kill();
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h1);
    next_cycle();
    drive(1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd9, 32'h2}) begin
      errors++; $display("FAIL kill_wb got we=%0b a=%0d d=%0h exp we=1 a=9 d=2", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL kill_pop_we got %0b exp 0", bus.rf_we); end
    next_cycle();
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL kill_after_we got %0b exp 0", bus.rf_we); end
    // Same-cycle enqueue and WB to the same register.
    next_cycle();
    drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd4, 32'h44);
    #1;
    checks++; if ({bus.rf_we, bus.rf_wdata} !== {1'b1, 32'h45}) begin
      errors++; $display("FAIL samecyc_wb got we=%0b d=%0h exp we=1 d=45", bus.rf_we, bus.rf_wdata); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL samecyc_kill_we got %0b exp 0", bus.rf_we); end
    // ll to r0: accepted, discarded.
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF);
    #1;
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", bus.ll_ready); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL r0_discard_we got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_hazard_fwd();
    next_cycle();
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h33);
    bus.raddr1 = 5'd3; bus.raddr2 = 5'd3;
    #1;
    checks++; if ({bus.busy1, bus.fwd1_valid} !== 2'b00) begin
      errors++; $display("FAIL enq_invisible got busy=%0b fwd=%0b exp 00", bus.busy1, bus.fwd1_valid); end
    next_cycle();
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd3, 32'h34);
    #1;
    checks++; if ({bus.busy1, bus.fwd1_valid, bus.fwd1_data} !== {!FWD, FWD, FWD ? 32'h33 : 32'h0}) begin
      errors++; $display("FAIL hit1 got busy=%0b fv=%0b fd=%0h exp busy=%0b fv=%0b fd=%0h",
                         bus.busy1, bus.fwd1_valid, bus.fwd1_data, !FWD, FWD, FWD ? 32'h33 : 32'h0); end
    next_cycle();
    drive(1'b1, 5'd1, 32'h100, 1'b0, 5'd0, 32'd0);
    bus.raddr2 = 5'd0;
    #1;
    checks++; if ({bus.busy1, bus.fwd1_valid, bus.fwd1_data} !== {!FWD, FWD, FWD ? 32'h34 : 32'h0}) begin
      errors++; $display("FAIL youngest1 got busy=%0b fv=%0b fd=%0h exp busy=%0b fv=%0b fd=%0h",
                         bus.busy1, bus.fwd1_valid, bus.fwd1_data, !FWD, FWD, FWD ? 32'h34 : 32'h0); end
    checks++; if ({bus.busy2, bus.fwd2_valid} !== 2'b00) begin
      errors++; $display("FAIL raddr0 got busy=%0b fv=%0b exp 00", bus.busy2, bus.fwd2_valid); end
    bus.raddr2 = 5'd3;
    #1;
    checks++; if ({bus.busy2, bus.fwd2_valid, bus.fwd2_data} !== {!FWD, FWD, FWD ? 32'h34 : 32'h0}) begin
      errors++; $display("FAIL hit2 got busy=%0b fv=%0b fd=%0h exp busy=%0b fv=%0b fd=%0h",
                         bus.busy2, bus.fwd2_valid, bus.fwd2_data, !FWD, FWD, FWD ? 32'h34 : 32'h0); end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin
      errors++; $display("FAIL fwd_drain0 got we=%0b a=%0d d=%0h exp we=1 a=3 d=33", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    next_cycle();
    #1;
    checks++; if ({bus.rf_we, bus.rf_wdata, bus.busy1} !== {1'b1, 32'h34, !FWD}) begin
      errors++; $display("FAIL fwd_drain1 got we=%0b d=%0h busy=%0b exp we=1 d=34 busy=%0b", bus.rf_we, bus.rf_wdata, bus.busy1, !FWD); end
    next_cycle();
    #1;
    checks++; if ({bus.busy1, bus.fwd1_valid, bus.rf_we} !== 3'b000) begin
      errors++; $display("FAIL fwd_empty got busy=%0b fv=%0b we=%0b exp 000", bus.busy1, bus.fwd1_valid, bus.rf_we); end
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1'b1, 5'd1, 32'h100, 1'b1, 5'(20 + i), 32'hC0 + 32'(i));
    end
    next_cycle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.raddr1 = 5'd21;
    #1;
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd20, 32'hC0}) begin
      errors++; $display("FAIL pre_rst_head got we=%0b a=%0d d=%0h exp we=1 a=20 d=c0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== 38'd0) begin
      errors++; $display("FAIL async_rst_rf got we=%0b a=%0d d=%0h exp 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if ({bus.ll_ready, bus.busy1, bus.fwd1_valid} !== 3'b000) begin
      errors++; $display("FAIL async_rst_ctl got rdy=%0b busy=%0b fv=%0b exp 000", bus.ll_ready, bus.busy1, bus.fwd1_valid); end
    next_cycle();
    reset = 1'b0;
    #1;
    checks++; if ({bus.ll_ready, bus.busy1, bus.fwd1_valid} !== 3'b100) begin
      errors++; $display("FAIL post_async_ctl got rdy=%0b busy=%0b fv=%0b exp 100", bus.ll_ready, bus.busy1, bus.fwd1_valid); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL stale_write[%0d] got %0b exp 0", i, bus.rf_we); end
      next_cycle();
      #1;
    end
    bus.raddr1 = 5'd0;
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    bus.raddr1 = 5'd0; bus.raddr2 = 5'd0;
    next_cycle();
    test_reset();
    test_wb_write();
    test_ll_drain();
    test_fill_drain();
    test_kill();
    test_hazard_fwd();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
